light_ctrl_axi_mem: RTL and testbench
=====================================

LIGHT_CTRL_AXI_MEM -- requirements
Module: light_ctrl_axi_mem

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 32, AXI data width (32 or 64).
REQ-002 SHALL have parameter C_ADDR_WIDTH, default 8, AXI byte-address width.
REQ-003 SHALL have parameter C_MEM_DEPTH, default 16, number of C_DATA_WIDTH words (power of two, at most 2^C_ADDR_WIDTH/(C_DATA_WIDTH/8)).
REQ-004 SHALL have parameter C_ID_WIDTH, default 1, AXI ID width.
REQ-005 SHALL have parameter C_NUM_CH, default 4, light channel count (1..C_MEM_DEPTH).
REQ-006 SHALL have parameter C_PWM_BITS, default 8, PWM resolution (1..C_DATA_WIDTH).
REQ-007 ACLK  in  1  sole clock; all logic rising-edge.
REQ-008 ARESETN  in  1  synchronous, active-low reset.
REQ-009 AW channel: AWID (C_ID_WIDTH), AWADDR (C_ADDR_WIDTH), AWLEN 8, AWSIZE 3, AWBURST 2, AWVALID in; AWREADY out.
REQ-010 W channel: WDATA (C_DATA_WIDTH), WSTRB (C_DATA_WIDTH/8), WLAST, WVALID in; WREADY out.
REQ-011 B channel: BID (C_ID_WIDTH), BRESP 2, BVALID out; BREADY in.
REQ-012 AR channel: ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID in (widths as AW); ARREADY out.
REQ-013 R channel: RID, RDATA (C_DATA_WIDTH), RRESP 2, RLAST, RVALID out; RREADY in.
REQ-014 light_out  out  C_NUM_CH  PWM output per channel.

Function
REQ-015 Write FSM SHALL use states W_IDLE, W_DATA, W_RESP; W_IDLE->W_DATA on AWVALID&&AWREADY, W_DATA->W_RESP on WVALID&&WREADY&&WLAST, W_RESP->W_IDLE on BVALID&&BREADY.
REQ-016 AWREADY SHALL be high only in W_IDLE; WREADY only in W_DATA; BVALID only in W_RESP.
REQ-017 Read FSM SHALL use states R_IDLE, R_DATA; ARREADY high only in R_IDLE; R_DATA entered on AR handshake, left on R handshake with RLAST.
REQ-018 First RVALID SHALL assert the cycle after the AR handshake; one beat per cycle while RREADY is high; RDATA/RLAST/RRESP held while RVALID&&!RREADY.
REQ-019 Write and read FSMs SHALL operate concurrently and independently.
REQ-020 Word index = address >> log2(C_DATA_WIDTH/8); address latched at A-handshake and advanced after each beat handshake.
REQ-021 FIXED burst: address constant; INCR: +bytes per beat; WRAP (len 2,4,8,16): wraps on a (len*bytes)-aligned boundary.
REQ-022 AWSIZE/ARSIZE other than log2(C_DATA_WIDTH/8), or AWBURST/ARBURST=3, or illegal WRAP length SHALL yield SLVERR for the whole burst.
REQ-023 Any beat whose word index >= C_MEM_DEPTH SHALL not write memory, SHALL return RDATA 0, and SHALL make the burst response SLVERR (per-beat RRESP on reads).
REQ-024 Writes SHALL apply per byte lane where WSTRB is 1; WSTRB=0 beats leave memory unchanged and are OKAY.
REQ-025 Same-cycle write and read beat to the same word SHALL return the pre-write value.
REQ-026 BID/RID SHALL echo the latched AWID/ARID.
REQ-027 WLAST asserted before or after the beat count implied by AWLEN SHALL end the burst at WLAST and return SLVERR.
REQ-028 A free-running C_PWM_BITS counter SHALL wrap from 2^C_PWM_BITS-1 to 0.
REQ-029 light_out[k] SHALL be registered as (counter < mem[k][C_PWM_BITS-1:0]); duty 0 gives constant 0.
REQ-030 A new duty value SHALL affect light_out starting the cycle after the write beat, without restarting the counter.

Reset
REQ-031 While ARESETN is low at a rising edge: both FSMs to idle; AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST 0; BRESP/RRESP 0; light_out 0; PWM counter 0; all memory words 0.
REQ-032 Reset asserted mid-burst SHALL abandon the burst, with no response generated after reset.
REQ-033 AWREADY and ARREADY SHALL assert on the first edge after ARESETN goes high.

Verification
REQ-034 INCR write, addr 0x00, AWLEN 7, data 1..8, WSTRB all ones -> BRESP OKAY; INCR read, addr 0x00, len 7 -> 1..8 with RLAST on beat 8 only.
REQ-035 WRAP write, addr 0x08, AWLEN 3, data A,B,C,D -> words 2,3,0,1 hold A,B,C,D; verified by INCR read from 0x00.
REQ-036 Word holds 0x11223344; write 0xAABBCCDD with WSTRB 0b0011 -> read back 0x1122CCDD.
REQ-037 Write to word index C_MEM_DEPTH -> BRESP SLVERR with memory unchanged; read of the same -> RDATA 0, RRESP SLVERR.
REQ-038 Write 64 to word 0 (C_PWM_BITS=8) -> light_out[0] high for exactly 64 of every 256 cycles; other channels 0.
REQ-039 Reset pulsed during beat 4 of an 8-beat write; RREADY held low for 3 cycles during a read -> FSMs idle, no BVALID; RDATA stable while stalled.

Source files
------------

// File: rtl/light_ctrl_axi_mem.sv
// AXI4 slave backed by a small word memory whose first C_NUM_CH words set
// the duty cycle of one PWM light output each.
module light_ctrl_axi_mem #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH = 8,
    parameter int C_MEM_DEPTH  = 16,
    parameter int C_ID_WIDTH   = 1,
    parameter int C_NUM_CH     = 4,
    parameter int C_PWM_BITS   = 8
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [C_ID_WIDTH-1:0]     AWID,
    input  logic [C_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]                AWLEN,
    input  logic [2:0]                AWSIZE,
    input  logic [1:0]                AWBURST,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [C_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                      WLAST,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [C_ID_WIDTH-1:0]     BID,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [C_ID_WIDTH-1:0]     ARID,
    input  logic [C_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]                ARLEN,
    input  logic [2:0]                ARSIZE,
    input  logic [1:0]                ARBURST,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [C_ID_WIDTH-1:0]     RID,
    output logic [C_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                RRESP,
    output logic                      RLAST,
    output logic                      RVALID,
    input  logic                      RREADY,
    output logic [C_NUM_CH-1:0]       light_out
);

    localparam int LP_BYTES  = C_DATA_WIDTH / 8;
    localparam int LP_LSB    = $clog2(LP_BYTES);
    localparam int LP_MIDXW  = (C_MEM_DEPTH > 1) ? $clog2(C_MEM_DEPTH) : 1;
    localparam logic [1:0] LP_OKAY   = 2'b00;
    localparam logic [1:0] LP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // Next beat address; the wrap window is (len+1)*bytes and is aligned to its own size.
    function automatic logic [C_ADDR_WIDTH-1:0] f_next_addr(
        input logic [C_ADDR_WIDTH-1:0] addr,
        input logic [1:0]              burst,
        input logic [7:0]              len
    );
        logic [C_ADDR_WIDTH-1:0] aligned;
        logic [C_ADDR_WIDTH-1:0] incr;
        logic [C_ADDR_WIDTH-1:0] mask;
        logic [31:0]             span;
        aligned = addr & ~C_ADDR_WIDTH'(LP_BYTES - 1);
        incr    = aligned + C_ADDR_WIDTH'(LP_BYTES);
        span    = (32'(len) + 32'd1) * 32'(LP_BYTES) - 32'd1;
        mask    = C_ADDR_WIDTH'(span);
        case (burst)
            2'b00:   f_next_addr = addr;
            2'b01:   f_next_addr = incr;
            2'b10:   f_next_addr = (aligned & ~mask) | (incr & mask);
            default: f_next_addr = addr;
        endcase
    endfunction

    function automatic logic f_burst_bad(
        input logic [2:0] size,
        input logic [1:0] burst,
        input logic [7:0] len
    );
        logic bad;
        bad = (size != 3'(LP_LSB)) || (burst == 2'b11);
        if (burst == 2'b10) begin
            bad = bad || !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
        end
        return bad;
    endfunction

    function automatic logic f_oor(input logic [C_ADDR_WIDTH-1:0] addr);
        logic [C_ADDR_WIDTH-1:0] idx;
        idx = addr >> LP_LSB;
        return 32'(idx) >= 32'(C_MEM_DEPTH);
    endfunction

    logic [C_DATA_WIDTH-1:0]  r_mem [C_MEM_DEPTH];

    w_state_t                 r_wstate;
    logic                     r_awready, r_wready, r_bvalid;
    logic [1:0]               r_bresp;
    logic [C_ID_WIDTH-1:0]    r_bid;
    logic [C_ADDR_WIDTH-1:0]  r_waddr;
    logic [7:0]               r_wlen, r_wcnt;
    logic [1:0]               r_wburst;
    logic                     r_wbad, r_werr;

    r_state_t                 r_rstate;
    logic                     r_arready, r_rvalid, r_rlast;
    logic [1:0]               r_rresp;
    logic [C_DATA_WIDTH-1:0]  r_rdata;
    logic [C_ID_WIDTH-1:0]    r_rid;
    logic [C_ADDR_WIDTH-1:0]  r_raddr;
    logic [7:0]               r_rlen, r_rcnt;
    logic [1:0]               r_rburst;
    logic                     r_rbad;

    logic [C_PWM_BITS-1:0]    r_pwm_cnt;
    logic [C_NUM_CH-1:0]      r_light;

    logic                     w_wr_oor;
    logic [LP_MIDXW-1:0]      w_wr_idx;
    logic [C_ADDR_WIDTH-1:0]  w_rd_addr;
    logic                     w_rd_oor;
    logic [LP_MIDXW-1:0]      w_rd_idx;
    logic [C_DATA_WIDTH-1:0]  w_rd_data;
    logic                     w_ar_bad;

    assign w_wr_oor  = f_oor(r_waddr);
    assign w_wr_idx  = r_waddr[LP_LSB +: LP_MIDXW];
    // The read port looks at the AR address while idle so the first beat is ready next cycle.
    assign w_rd_addr = (r_rstate == R_IDLE) ? ARADDR : r_raddr;
    assign w_rd_oor  = f_oor(w_rd_addr);
    assign w_rd_idx  = w_rd_addr[LP_LSB +: LP_MIDXW];
    assign w_rd_data = w_rd_oor ? {C_DATA_WIDTH{1'b0}} : r_mem[w_rd_idx];
    assign w_ar_bad  = f_burst_bad(ARSIZE, ARBURST, ARLEN);

    // Write channel FSM and memory update.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= LP_OKAY;
            r_bid     <= {C_ID_WIDTH{1'b0}};
            r_waddr   <= {C_ADDR_WIDTH{1'b0}};
            r_wlen    <= 8'd0;
            r_wcnt    <= 8'd0;
            r_wburst  <= 2'b00;
            r_wbad    <= 1'b0;
            r_werr    <= 1'b0;
            for (int i = 0; i < C_MEM_DEPTH; i++) begin
                r_mem[i] <= {C_DATA_WIDTH{1'b0}};
            end
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (AWVALID && r_awready) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_waddr   <= AWADDR;
                        r_wlen    <= AWLEN;
                        r_wburst  <= AWBURST;
                        r_bid     <= AWID;
                        r_wcnt    <= 8'd0;
                        r_wbad    <= f_burst_bad(AWSIZE, AWBURST, AWLEN);
                        r_werr    <= f_burst_bad(AWSIZE, AWBURST, AWLEN);
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (WVALID && r_wready) begin
                        if (!r_wbad && !w_wr_oor) begin
                            for (int b = 0; b < LP_BYTES; b++) begin
                                if (WSTRB[b]) begin
                                    r_mem[w_wr_idx][8*b +: 8] <= WDATA[8*b +: 8];
                                end
                            end
                        end
                        r_waddr <= f_next_addr(r_waddr, r_wburst, r_wlen);
                        if (r_wcnt != 8'hFF) begin
                            r_wcnt <= r_wcnt + 8'd1;
                        end
                        if (WLAST) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr || w_wr_oor || (r_wcnt != r_wlen)) ? LP_SLVERR : LP_OKAY;
                            r_wstate <= W_RESP;
                        end else begin
                            // A non-last beat at the final count means WLAST is overdue.
                            r_werr <= r_werr | w_wr_oor | (r_wcnt == r_wlen);
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY && r_bvalid) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM; RDATA/RRESP/RLAST only change on a handshake.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= LP_OKAY;
            r_rdata   <= {C_DATA_WIDTH{1'b0}};
            r_rid     <= {C_ID_WIDTH{1'b0}};
            r_raddr   <= {C_ADDR_WIDTH{1'b0}};
            r_rlen    <= 8'd0;
            r_rcnt    <= 8'd0;
            r_rburst  <= 2'b00;
            r_rbad    <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (ARVALID && r_arready) begin
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rid     <= ARID;
                        r_rlen    <= ARLEN;
                        r_rburst  <= ARBURST;
                        r_rbad    <= w_ar_bad;
                        r_rcnt    <= 8'd0;
                        r_rdata   <= w_rd_data;
                        r_rresp   <= (w_ar_bad || w_rd_oor) ? LP_SLVERR : LP_OKAY;
                        r_rlast   <= (ARLEN == 8'd0);
                        r_raddr   <= f_next_addr(ARADDR, ARBURST, ARLEN);
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RREADY && r_rvalid) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_rdata <= w_rd_data;
                            r_rresp <= (r_rbad || w_rd_oor) ? LP_SLVERR : LP_OKAY;
                            r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
                            r_rcnt  <= r_rcnt + 8'd1;
                            r_raddr <= f_next_addr(r_raddr, r_rburst, r_rlen);
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // Free-running PWM counter and per-channel duty compare.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_pwm_cnt <= {C_PWM_BITS{1'b0}};
            r_light   <= {C_NUM_CH{1'b0}};
        end else begin
            r_pwm_cnt <= r_pwm_cnt + {{(C_PWM_BITS-1){1'b0}}, 1'b1};
            for (int k = 0; k < C_NUM_CH; k++) begin
                r_light[k] <= (r_pwm_cnt < r_mem[k][C_PWM_BITS-1:0]);
            end
        end
    end

    assign AWREADY   = r_awready;
    assign WREADY    = r_wready;
    assign BVALID    = r_bvalid;
    assign BRESP     = r_bresp;
    assign BID       = r_bid;
    assign ARREADY   = r_arready;
    assign RVALID    = r_rvalid;
    assign RLAST     = r_rlast;
    assign RRESP     = r_rresp;
    assign RDATA     = r_rdata;
    assign RID       = r_rid;
    assign light_out = r_light;

endmodule

// File: tb/tb_light_ctrl_axi_mem.sv
// Directed bench for light_ctrl_axi_mem: bursts, strobes, error responses,
// read stall, PWM duty and mid-burst reset.
module tb_light_ctrl_axi_mem;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [0:0]  AWID, BID, ARID, RID;
    logic [7:0]  AWADDR, ARADDR, AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [3:0]  light_out;

    logic [31:0] wbuf [16];
    logic [31:0] rexp [16];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 ACLK = ~ACLK;

    light_ctrl_axi_mem dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .light_out(light_out)
    );

    task automatic chk_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic sel_sig(input int sel);
        case (sel)
            0:       return AWREADY;
            1:       return WREADY;
            2:       return BVALID;
            3:       return ARREADY;
            4:       return RVALID;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_hi(input string tag, input int sel);
        int n = 0;
        while (!sel_sig(sel) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk_value({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic axi_write(input string tag, input logic [7:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [2:0] size, input logic [3:0] strb,
                             input int last_at, input logic id, input logic [1:0] exp_resp);
        AWADDR = addr; AWLEN = len; AWBURST = burst; AWSIZE = size; AWID = id; AWVALID = 1'b1;
        wait_hi(tag, 0);
        tick();
        AWVALID = 1'b0;
        WVALID  = 1'b1;
        for (int i = 0; i <= last_at; i++) begin
            WDATA = wbuf[i]; WSTRB = strb; WLAST = (i == last_at);
            wait_hi(tag, 1);
            tick();
        end
        WVALID = 1'b0; WLAST = 1'b0;
        BREADY = 1'b1;
        wait_hi(tag, 2);
        chk_value({tag, "_bresp"}, 64'(BRESP), 64'(exp_resp));
        chk_value({tag, "_bid"}, 64'(BID), 64'(id));
        tick();
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input string tag, input logic [7:0] addr, input logic [7:0] len,
                            input logic id, input logic [1:0] exp_resp, input int stall_beat);
        ARADDR = addr; ARLEN = len; ARBURST = 2'b01; ARSIZE = 3'd2; ARID = id; ARVALID = 1'b1;
        wait_hi(tag, 3);
        tick();
        ARVALID = 1'b0;
        chk_value({tag, "_rvalid_lat"}, 64'(RVALID), 64'd1);
        for (int i = 0; i <= int'(len); i++) begin
            wait_hi(tag, 4);
            if (i == stall_beat) begin
                RREADY = 1'b0;
                repeat (3) tick();
                chk_value({tag, "_stall_rvalid"}, 64'(RVALID), 64'd1);
                chk_value({tag, "_stall_rdata"}, 64'(RDATA), 64'(rexp[i]));
            end
            chk_value({tag, "_rdata"}, 64'(RDATA), 64'(rexp[i]));
            chk_value({tag, "_rlast"}, 64'(RLAST), 64'(i == int'(len)));
            chk_value({tag, "_rresp"}, 64'(RRESP), 64'(exp_resp));
            chk_value({tag, "_rid"}, 64'(RID), 64'(id));
            RREADY = 1'b1;
            tick();
            RREADY = 1'b0;
        end
    endtask

    initial begin
        int hi;
        logic [3:1] oth;
        ARESETN = 1'b0;
        AWID = 1'b0; AWADDR = 8'd0; AWLEN = 8'd0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b0;
        WDATA = 32'd0; WSTRB = 4'd0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = 1'b0; ARADDR = 8'd0; ARLEN = 8'd0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b0;
        RREADY = 1'b0;

        repeat (3) tick();
        chk_value("rst_awready", 64'(AWREADY), 64'd0);
        chk_value("rst_arready", 64'(ARREADY), 64'd0);
        chk_value("rst_bvalid", 64'(BVALID), 64'd0);
        chk_value("rst_rvalid", 64'(RVALID), 64'd0);
        chk_value("rst_light", 64'(light_out), 64'd0);
        ARESETN = 1'b1;
        tick();
        chk_value("rel_awready", 64'(AWREADY), 64'd1);
        chk_value("rel_arready", 64'(ARREADY), 64'd1);

        // INCR 8-beat write and readback
        for (int i = 0; i < 8; i++) begin
            wbuf[i] = 32'(i + 1);
            rexp[i] = 32'(i + 1);
        end
        axi_write("incr_wr", 8'h00, 8'd7, 2'b01, 3'd2, 4'hF, 7, 1'b1, 2'b00);
        axi_read("incr_rd", 8'h00, 8'd7, 1'b1, 2'b00, -1);

        // WRAP from 0x08: words 2,3,0,1 <= A,B,C,D; readback stalled on beat 1
        wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
        axi_write("wrap_wr", 8'h08, 8'd3, 2'b10, 3'd2, 4'hF, 3, 1'b0, 2'b00);
        rexp[0] = 32'hC; rexp[1] = 32'hD; rexp[2] = 32'hA; rexp[3] = 32'hB;
        axi_read("wrap_rd", 8'h00, 8'd3, 1'b0, 2'b00, 1);

        // Byte strobes on word 4
        wbuf[0] = 32'h11223344;
        axi_write("strb_init", 8'h10, 8'd0, 2'b01, 3'd2, 4'hF, 0, 1'b0, 2'b00);
        wbuf[0] = 32'hAABBCCDD;
        axi_write("strb_wr", 8'h10, 8'd0, 2'b01, 3'd2, 4'b0011, 0, 1'b0, 2'b00);
        rexp[0] = 32'h1122CCDD;
        axi_read("strb_rd", 8'h10, 8'd0, 1'b0, 2'b00, -1);

        // Out-of-range word index 16; word 0 must keep C
        wbuf[0] = 32'hDEADBEEF;
        axi_write("oor_wr", 8'h40, 8'd0, 2'b01, 3'd2, 4'hF, 0, 1'b1, 2'b10);
        rexp[0] = 32'd0;
        axi_read("oor_rd", 8'h40, 8'd0, 1'b1, 2'b10, -1);
        rexp[0] = 32'hC;
        axi_read("oor_keep", 8'h00, 8'd0, 1'b0, 2'b00, -1);

        // Protocol errors: bad size, early WLAST, late WLAST
        wbuf[0] = 32'h5; wbuf[1] = 32'h6;
        axi_write("bad_size", 8'h14, 8'd0, 2'b01, 3'd1, 4'hF, 0, 1'b0, 2'b10);
        axi_write("early_last", 8'h18, 8'd3, 2'b01, 3'd2, 4'hF, 1, 1'b0, 2'b10);
        axi_write("late_last", 8'h18, 8'd0, 2'b01, 3'd2, 4'hF, 1, 1'b0, 2'b10);

        // PWM: duty 64 on channel 0, others 0
        wbuf[0] = 32'd64; wbuf[1] = 32'd0; wbuf[2] = 32'd0; wbuf[3] = 32'd0;
        axi_write("pwm_wr", 8'h00, 8'd3, 2'b01, 3'd2, 4'hF, 3, 1'b0, 2'b00);
        repeat (2) tick();
        hi = 0;
        oth = 3'd0;
        for (int c = 0; c < 256; c++) begin
            hi  = hi + int'(light_out[0]);
            oth = oth | light_out[3:1];
            tick();
        end
        chk_value("pwm_hi", 64'(hi), 64'd64);
        chk_value("pwm_others", 64'(oth), 64'd0);

        // Reset pulsed during beat 4 of an 8-beat write
        AWADDR = 8'h20; AWLEN = 8'd7; AWBURST = 2'b01; AWSIZE = 3'd2; AWID = 1'b0; AWVALID = 1'b1;
        wait_hi("rst_mid", 0);
        tick();
        AWVALID = 1'b0;
        WVALID = 1'b1; WSTRB = 4'hF; WLAST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            WDATA = 32'(i + 100);
            wait_hi("rst_mid", 1);
            tick();
        end
        WDATA = 32'd103;
        ARESETN = 1'b0;
        tick();
        ARESETN = 1'b1;
        WVALID = 1'b0;
        chk_value("rst_mid_wready", 64'(WREADY), 64'd0);
        chk_value("rst_mid_bvalid", 64'(BVALID), 64'd0);
        chk_value("rst_mid_light", 64'(light_out), 64'd0);
        tick();
        chk_value("rst_mid_awready", 64'(AWREADY), 64'd1);
        chk_value("rst_mid_arready", 64'(ARREADY), 64'd1);
        repeat (5) tick();
        chk_value("rst_mid_no_b", 64'(BVALID), 64'd0);
        rexp[0] = 32'd0;
        axi_read("rst_mid_mem", 8'h00, 8'd0, 1'b0, 2'b00, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
